tone_generator: RTL and testbench
=================================

TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have parameter GAP_MS, default 10: silent inter-note gap in milliseconds, range 0..255.
REQ-002 SHALL have parameter TPM_W, default 16: width of ticks_per_milli.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ticks_per_milli  input  TPM_W  clk cycles per millisecond; a value of 0 SHALL be treated as 1.
REQ-006 note_valid  input  1  note request from the sequencer.
REQ-007 note_ready  output  1  high only in IDLE.
REQ-008 note_half_period  input  16  square-wave half period in clk cycles; 0 = rest (silence).
REQ-009 note_ms  input  8  note duration in milliseconds.
REQ-010 stop  input  1  synchronous abort.
REQ-011 sound  output  1  registered square-wave speaker drive.
REQ-012 busy  output  1  high in PLAY or GAP.
REQ-013 done  output  1  one-cycle pulse when a note (including its gap) completes.

Function
REQ-014 SHALL implement states IDLE, PLAY, GAP.
REQ-015 Handshake SHALL occur on note_valid && note_ready at a rising edge; note_half_period and note_ms SHALL be latched at that edge and ignored afterwards.
REQ-016 On handshake with note_ms==0: remain in IDLE; assert done in the next cycle; sound stays 0.
REQ-017 On handshake with note_ms>0: enter PLAY in the next cycle; clear the ms prescaler and the tone counter; set sound to 0.
REQ-018 Ms prescaler: counts 0..ticks_per_milli-1 in PLAY and GAP; wraps to 0 on the terminal value, producing a one-cycle ms_tick.
REQ-019 PLAY SHALL last exactly note_ms*ticks_per_milli cycles.
REQ-020 Tone counter in PLAY: counts 0..half_period-1; on the terminal value it wraps to 0 and sound toggles at that edge. First toggle: sound reads 1 from PLAY cycle index half_period (0-based).
REQ-021 A half_period of 1 SHALL toggle sound every cycle.
REQ-022 A half_period of 0 SHALL hold sound at 0 for the entire PLAY.
REQ-023 PLAY->GAP: at the last PLAY cycle, sound SHALL be forced to 0 and the prescaler cleared.
REQ-024 GAP: sound=0 for exactly GAP_MS*ticks_per_milli cycles, then IDLE. If GAP_MS==0, PLAY SHALL go directly to IDLE.
REQ-025 done SHALL be high for exactly the first IDLE cycle after PLAY/GAP completes; note_ready is high in that same cycle.
REQ-026 A back-to-back note accepted in that cycle SHALL enter PLAY on the next cycle (no bubble beyond the done cycle).
REQ-027 stop in PLAY or GAP SHALL force IDLE at the next edge, with sound=0, no done pulse, and counters cleared; stop in IDLE SHALL be ignored.
REQ-028 stop and note_valid both high in IDLE: the note SHALL be accepted.
REQ-029 A ticks_per_milli change mid-note SHALL take effect at the next prescaler compare; no correction of elapsed time.
REQ-030 Counters SHALL not overflow: ms counter 8 bits, tone counter 16 bits, prescaler TPM_W bits.

Reset
REQ-031 rst high SHALL immediately set: state IDLE, sound=0, done=0, busy=0, all counters 0, latched note fields 0.
REQ-032 note_ready SHALL read 1 while rst is high and after release.
REQ-033 Reset mid-PLAY SHALL abort with no done pulse.
REQ-034 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-035 tpm=4, GAP_MS=1, hp=3, ms=2 -> PLAY lasts 8 cycles with sound 0,0,0,1,1,1,0,0; GAP 4 cycles at 0; done at cycle 13 after handshake.
REQ-036 hp=0, ms=3, tpm=2 -> sound 0 throughout; busy for 6+2*GAP_MS cycles; single done pulse.
REQ-037 ms=0 -> busy never rises; done one cycle after the handshake; sound 0.
REQ-038 stop at PLAY cycle 5 -> IDLE next cycle, sound 0, no done; a following note is accepted normally.
REQ-039 rst asserted mid-GAP asynchronously -> outputs reach their reset values before the next clk edge.
REQ-040 Back-to-back notes with note_valid held high -> second PLAY starts the cycle after done; tpm=0 behaves as tpm=1.

Source files
------------

// File: rtl/tone_generator.sv
// Square-wave tone generator: plays one note (tone or rest) for note_ms milliseconds,
// follows it with a silent GAP_MS gap, then pulses done and returns to IDLE.
module tone_generator #(
   parameter int GAP_MS = 10,
   parameter int TPM_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [TPM_W-1:0] ticks_per_milli,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [15:0]      note_half_period,
   input  logic [7:0]       note_ms,
   input  logic             stop,
   output logic             sound,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam logic [7:0] GAP_MS_L = 8'(GAP_MS);

   state_t           state, state_nx;
   logic [TPM_W-1:0] presc, presc_nx, tpm_eff;
   logic [15:0]      tone_cnt, tone_nx, half_q, half_nx;
   logic [7:0]       ms_left, ms_nx;
   logic             sound_nx, done_nx, ms_tick;

   // A zero tick rate is treated as one tick per millisecond; the >= compare
   // keeps a mid-note rate decrease from running the prescaler past its end.
   always_comb begin
      tpm_eff = (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
      ms_tick = (state != IDLE) && (presc >= tpm_eff - TPM_W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         presc    <= '0;
         tone_cnt <= '0;
         half_q   <= '0;
         ms_left  <= '0;
         sound    <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         presc    <= presc_nx;
         tone_cnt <= tone_nx;
         half_q   <= half_nx;
         ms_left  <= ms_nx;
         sound    <= sound_nx;
         done     <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      presc_nx = presc;
      tone_nx  = tone_cnt;
      half_nx  = half_q;
      ms_nx    = ms_left;
      sound_nx = sound;
      done_nx  = 1'b0;

      case (state)
         IDLE: begin
            if (note_valid) begin
               half_nx = note_half_period;
               if (note_ms == 8'd0) begin
                  done_nx = 1'b1;
               end else begin
                  state_nx = PLAY;
                  ms_nx    = note_ms;
                  presc_nx = '0;
                  tone_nx  = '0;
                  sound_nx = 1'b0;
               end
            end
         end

         PLAY: begin
            presc_nx = ms_tick ? '0 : presc + TPM_W'(1);
            if (half_q == 16'd0) begin
               sound_nx = 1'b0;
            end else if (tone_cnt >= half_q - 16'd1) begin
               tone_nx  = '0;
               sound_nx = ~sound;
            end else begin
               tone_nx = tone_cnt + 16'd1;
            end
            // The last millisecond of the note ends the tone and starts the gap.
            if (ms_tick) begin
               if (ms_left <= 8'd1) begin
                  sound_nx = 1'b0;
                  presc_nx = '0;
                  tone_nx  = '0;
                  if (GAP_MS_L == 8'd0) begin
                     state_nx = IDLE;
                     ms_nx    = '0;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = GAP;
                     ms_nx    = GAP_MS_L;
                  end
               end else begin
                  ms_nx = ms_left - 8'd1;
               end
            end
         end

         GAP: begin
            sound_nx = 1'b0;
            presc_nx = ms_tick ? '0 : presc + TPM_W'(1);
            if (ms_tick) begin
               if (ms_left <= 8'd1) begin
                  state_nx = IDLE;
                  ms_nx    = '0;
                  done_nx  = 1'b1;
               end else begin
                  ms_nx = ms_left - 8'd1;
               end
            end
         end

         default: state_nx = IDLE;
      endcase

      // An abort drops everything without signalling completion.
      if (stop && state != IDLE) begin
         state_nx = IDLE;
         presc_nx = '0;
         tone_nx  = '0;
         ms_nx    = '0;
         sound_nx = 1'b0;
         done_nx  = 1'b0;
      end
   end

   assign note_ready = (state == IDLE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator: directed scenarios plus random notes
// compared against an arithmetic model of the expected waveform.
module tb_tone_generator;

   localparam int GAP_MS = 1;
   localparam int TPM_W  = 16;

   logic             clk;
   logic             rst;
   logic [TPM_W-1:0] ticks_per_milli;
   logic             note_valid;
   logic             note_ready;
   logic [15:0]      note_half_period;
   logic [7:0]       note_ms;
   logic             stop;
   logic             sound;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   tone_generator #(.GAP_MS(GAP_MS), .TPM_W(TPM_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .ticks_per_milli  (ticks_per_milli),
      .note_valid       (note_valid),
      .note_ready       (note_ready),
      .note_half_period (note_half_period),
      .note_ms          (note_ms),
      .stop             (stop),
      .sound            (sound),
      .busy             (busy),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected sound in PLAY cycle i: the wave is low for the first half period,
   // then alternates every half period; a rest stays low.
   function automatic logic model_sound(input int hp, input int i);
      if (hp == 0) return 1'b0;
      return 1'(((i / hp) % 2) == 1);
   endfunction

   // Plays one note from an IDLE negedge and checks every cycle until one
   // cycle after the done pulse. Returns at a negedge with the DUT idle.
   task automatic run_note(input int hp, input int ms, input int tpm, input logic with_stop);
      int te, play_len, gap_len;
      logic exp_sound, exp_busy, exp_done;
      te       = (tpm == 0) ? 1 : tpm;
      play_len = ms * te;
      gap_len  = (ms == 0) ? 0 : GAP_MS * te;
      ticks_per_milli  = TPM_W'(tpm);
      note_half_period = 16'(hp);
      note_ms          = 8'(ms);
      note_valid       = 1'b1;
      stop             = with_stop;
      checks++;
      if (note_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL note_ready_at_handshake actual=%b expected=1", note_ready);
      end
      @(negedge clk);
      note_valid       = 1'b0;
      stop             = 1'b0;
      note_half_period = 16'($urandom);
      note_ms          = 8'($urandom);
      for (int i = 0; i <= play_len + gap_len; i++) begin
         if (i < play_len) begin
            exp_sound = model_sound(hp, i);
            exp_busy  = 1'b1;
            exp_done  = 1'b0;
         end else if (i < play_len + gap_len) begin
            exp_sound = 1'b0;
            exp_busy  = 1'b1;
            exp_done  = 1'b0;
         end else begin
            exp_sound = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b1;
         end
         checks++;
         if (sound !== exp_sound || busy !== exp_busy || done !== exp_done ||
             note_ready !== !exp_busy) begin
            errors++;
            $display("[TB] FAIL note_cycle hp=%0d ms=%0d tpm=%0d i=%0d actual sound/busy/done/ready=%b%b%b%b expected=%b%b%b%b",
                     hp, ms, tpm, i, sound, busy, done, note_ready,
                     exp_sound, exp_busy, exp_done, !exp_busy);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sound !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_done hp=%0d ms=%0d actual done/busy/sound=%b%b%b expected=000",
                  hp, ms, done, busy, sound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (note_ready !== 1'b1 || sound !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state actual ready/sound/busy/done=%b%b%b%b expected=1000",
                  note_ready, sound, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_example();
      run_note(3, 2, 4, 1'b0);
   endtask

   task automatic test_rest();
      run_note(0, 3, 2, 1'b0);
   endtask

   task automatic test_zero_ms();
      run_note(5, 0, 3, 1'b0);
   endtask

   task automatic test_stop();
      ticks_per_milli  = 16'd4;
      note_half_period = 16'd2;
      note_ms          = 8'd3;
      note_valid       = 1'b1;
      @(negedge clk);
      note_valid = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || sound !== 1'b0 || done !== 1'b0 || note_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stop_abort actual busy/sound/done/ready=%b%b%b%b expected=0001",
                  busy, sound, done, note_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_no_done i=%0d actual done/busy=%b%b expected=00", i, done, busy);
         end
      end
      run_note(2, 1, 3, 1'b0);
   endtask

   // Reset is raised between clock edges, once with sound high in PLAY and once in GAP.
   task automatic test_async_reset();
      int stop_at [2] = '{1, 4};
      for (int p = 0; p < 2; p++) begin
         ticks_per_milli  = 16'd3;
         note_half_period = 16'd1;
         note_ms          = 8'd1;
         note_valid       = 1'b1;
         @(negedge clk);
         note_valid = 1'b0;
         for (int i = 0; i < stop_at[p]; i++) @(negedge clk);
         #2 rst = 1'b1;
         #1;
         checks++;
         if (busy !== 1'b0 || sound !== 1'b0 || done !== 1'b0 || note_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset phase=%0d actual busy/sound/done/ready=%b%b%b%b expected=0001",
                     p, busy, sound, done, note_ready);
         end
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_done phase=%0d actual done/busy=%b%b expected=00", p, done, busy);
         end
      end
      run_note(1, 2, 2, 1'b0);
   endtask

   // note_valid held high with tpm=0: each period is PLAY(2) GAP(1) done(1),
   // and the done cycle doubles as the next handshake.
   task automatic test_back_to_back();
      int j;
      logic exp_sound, exp_busy, exp_done;
      ticks_per_milli  = 16'd0;
      note_half_period = 16'd1;
      note_ms          = 8'd2;
      note_valid       = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         j = i % 4;
         exp_sound = (j < 2) ? model_sound(1, j) : 1'b0;
         exp_busy  = (j < 3);
         exp_done  = (j == 3);
         checks++;
         if (sound !== exp_sound || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("[TB] FAIL back_to_back i=%0d actual sound/busy/done=%b%b%b expected=%b%b%b",
                     i, sound, busy, done, exp_sound, exp_busy, exp_done);
         end
         if (i == 7) note_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL back_to_back_end actual busy/done=%b%b expected=00", busy, done);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         run_note(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst              = 1'b1;
      ticks_per_milli  = '0;
      note_valid       = 1'b0;
      note_half_period = '0;
      note_ms          = '0;
      stop             = 1'b0;
      @(negedge clk);
      test_reset();
      test_example();
      test_rest();
      test_zero_ms();
      test_stop();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
